// File: rtl/sort_pkg.sv
// Shared defaults and FSM state type for the sort_drain slice.
package sort_pkg;

  localparam int unsigned SORT_DATAWIDTH = 8;
  localparam int unsigned SORT_ADDRWIDTH = 9;
  localparam int unsigned SORT_DEPTH     = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SEND,
    ST_FINISH
  } drain_state_t;

endpackage

// File: rtl/sort_order_chk.sv
// Tracks the previously accepted word and raises a sticky flag when a
// freshly captured word is smaller than it.
module sort_order_chk
  import sort_pkg::*;
#(
  parameter int unsigned DATAWIDTH = SORT_DATAWIDTH
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_check,
  input  logic                 i_first,
  input  logic [DATAWIDTH-1:0] i_data,
  input  logic                 i_accept,
  input  logic [DATAWIDTH-1:0] i_acc_data,
  output logic                 o_err
);

  logic [DATAWIDTH-1:0] r_prev;
  logic                 r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_err  <= 1'b0;
    end else begin
      if (i_accept)
        r_prev <= i_acc_data;
      if (i_clr)
        r_err <= 1'b0;
      else if (i_check && !i_first && (i_data < r_prev))
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/sort_drain.sv
// Streams the sorter's result memory out over valid/ready after each done
// pulse, counting accepted words and flagging any descending step.
module sort_drain
  import sort_pkg::*;
#(
  parameter int unsigned DATAWIDTH = SORT_DATAWIDTH,
  parameter int unsigned ADDRWIDTH = SORT_ADDRWIDTH,
  parameter int unsigned DEPTH     = SORT_DEPTH
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done,
  input  logic [ADDRWIDTH-1:0] n,
  output logic                 mem_rd,
  output logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 drain_done,
  output logic                 order_err,
  output logic [ADDRWIDTH-1:0] out_count
);

  localparam logic [ADDRWIDTH:0]   DEPTH_W = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH-1:0] ONE     = ADDRWIDTH'(1);

  drain_state_t r_state, w_next;

  logic [ADDRWIDTH-1:0] r_n_lat;
  logic [ADDRWIDTH-1:0] r_idx;
  logic [ADDRWIDTH-1:0] r_addr_hold;
  logic [ADDRWIDTH-1:0] r_out_count;
  logic [DATAWIDTH-1:0] r_out_data;
  logic                 r_out_last;

  logic                 w_start;
  logic                 w_capture;
  logic                 w_accept;
  logic [ADDRWIDTH-1:0] w_n_clamp;

  // One extra bit so a DEPTH equal to 2**ADDRWIDTH still compares correctly.
  assign w_n_clamp = ({1'b0, n} > DEPTH_W) ? DEPTH_W[ADDRWIDTH-1:0] : n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (done) begin
          w_start = 1'b1;
          w_next  = (w_n_clamp == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH:   w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          w_accept = 1'b1;
          w_next   = r_out_last ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_lat     <= '0;
      r_idx       <= '0;
      r_addr_hold <= '0;
      r_out_count <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_start) begin
        r_n_lat     <= w_n_clamp;
        r_idx       <= '0;
        r_out_count <= '0;
      end
      if (r_state == ST_FETCH)
        r_addr_hold <= r_idx;
      if (w_capture) begin
        r_out_data <= mem_rdata;
        r_out_last <= (r_idx == (r_n_lat - ONE));
      end
      if (w_accept) begin
        r_out_count <= r_out_count + ONE;
        if (!r_out_last)
          r_idx <= r_idx + ONE;
      end
    end
  end

  sort_order_chk #(
    .DATAWIDTH (DATAWIDTH)
  ) u_order_chk (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start),
    .i_check    (w_capture),
    .i_first    (r_idx == '0),
    .i_data     (mem_rdata),
    .i_accept   (w_accept),
    .i_acc_data (r_out_data),
    .o_err      (order_err)
  );

  // Address is driven live in FETCH and parked at the last fetched index otherwise.
  assign mem_addr   = (r_state == ST_FETCH) ? r_idx : r_addr_hold;
  assign mem_rd     = (r_state == ST_FETCH);
  assign out_valid  = (r_state == ST_SEND);
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign out_count  = r_out_count;
  assign busy       = (r_state == ST_FETCH) || (r_state == ST_CAPTURE) || (r_state == ST_SEND);
  assign drain_done = (r_state == ST_FINISH);

endmodule

// File: tb/tb_sort_drain.sv
// Randomized self-checking bench for sort_drain against an array-based
// model of the expected drained stream.
module tb_sort_drain;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          done;
  logic [AW-1:0] n;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          drain_done;
  logic          order_err;
  logic [AW-1:0] out_count;

  logic [DW-1:0] ram [0:DEPTH-1];

  int n_vec = 0;
  int n_err = 0;

  sort_drain #(
    .DATAWIDTH (DW),
    .ADDRWIDTH (AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .n          (n),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .drain_done (drain_done),
    .order_err  (order_err),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  // Result RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd)
      mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drain one buffer of nn words; rmode 0 = ready always, 1 = 1-of-4, 2 = random.
  task automatic run_drain(input int nn, input int rmode, input int stray_cyc);
    int nlat, k, cyc, dd_seen, first_valid, budget;
    bit err_exp, err_final, stalled, fin;
    nlat = (nn > DEPTH) ? DEPTH : nn;
    err_final = 1'b0;
    for (int i = 1; i < nlat; i++)
      if (ram[i] < ram[i-1]) err_final = 1'b1;
    k = 0; cyc = 0; dd_seen = 0; first_valid = -1;
    err_exp = 1'b0; stalled = 1'b0; fin = 1'b0;
    budget = nlat * 12 + 20;

    @(negedge clk);
    done = 1'b1;
    n    = AW'(nn);
    @(negedge clk);
    done = 1'b0;
    n    = AW'($urandom);
    cyc  = 1;

    while (!fin && cyc < budget) begin
      if (cyc == 1) begin
        chk("busy_after_done", 32'(busy), 32'(nlat > 0));
        chk("err_cleared", 32'(order_err), 32'(0));
        chk("count_cleared", 32'(out_count), 32'(0));
      end
      if (mem_rd) begin
        chk("rd_in_range", 32'(k < nlat), 32'(1));
        chk("rd_addr", 32'(mem_addr), 32'(k));
      end
      if (stalled)
        chk("valid_held", 32'(out_valid), 32'(1));
      stalled = 1'b0;

      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase

      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk("first_latency", 32'(cyc), 32'(3));
        end
        chk("word_in_range", 32'(k < nlat), 32'(1));
        if (k > 0 && k < nlat && ram[k] < ram[k-1]) err_exp = 1'b1;
        chk("data", 32'(out_data), (k < nlat) ? 32'(ram[k]) : 32'hFFFF_FFFF);
        chk("last", 32'(out_last), 32'(k == nlat - 1));
        chk("count_live", 32'(out_count), 32'(k));
        chk("err_live", 32'(order_err), 32'(err_exp));
        if (out_ready) k++;
        else           stalled = 1'b1;
      end

      if (drain_done) begin
        dd_seen++;
        if (nlat == 0) chk("n0_done_latency", 32'(cyc), 32'(1));
        chk("words_emitted", 32'(k), 32'(nlat));
        chk("count_final", 32'(out_count), 32'(nlat));
        chk("err_final", 32'(order_err), 32'(err_final));
        chk("busy_at_finish", 32'(busy), 32'(0));
        fin = 1'b1;
      end

      if (cyc == stray_cyc) begin
        done = 1'b1;
        n    = AW'(5);
      end else begin
        done = 1'b0;
      end

      @(negedge clk);
      cyc++;
    end
    done = 1'b0;
    chk("drain_done_seen", 32'(dd_seen), 32'(1));
    chk("drain_done_pulse", 32'(drain_done), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("count_after", 32'(out_count), 32'(nlat));
  endtask

  task automatic abort_drain();
    int k, cyc;
    bit hit;
    k = 0; cyc = 0; hit = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    done = 1'b1;
    n    = AW'(33);
    @(negedge clk);
    done = 1'b0;
    while (!hit && cyc < 200) begin
      if (out_valid) begin
        if (k == 10) hit = 1'b1;
        else         k++;
      end
      if (!hit) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("abort_reached_word10", 32'(hit), 32'(1));
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_count", 32'(out_count), 32'(0));
    chk("abort_rd", 32'(mem_rd), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      chk("abort_no_done", 32'(drain_done), 32'(0));
    end
  endtask

  task automatic fill_sorted(input int len);
    for (int i = 0; i < DEPTH; i++)
      ram[i] = (i < len) ? DW'(i + 1) : DW'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    done      = 1'b0;
    n         = '0;
    out_ready = 1'b0;
    fill_sorted(33);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rd", 32'(mem_rd), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_last", 32'(out_last), 32'(0));
    chk("rst_done", 32'(drain_done), 32'(0));
    chk("rst_err", 32'(order_err), 32'(0));
    chk("rst_count", 32'(out_count), 32'(0));
    rst = 1'b0;

    run_drain(33, 0, -1);
    run_drain(33, 1, -1);

    ram[0] = 8'd5; ram[1] = 8'd7; ram[2] = 8'd6; ram[3] = 8'd9;
    run_drain(4, 0, -1);
    chk("err_sticky_idle", 32'(order_err), 32'(1));
    fill_sorted(33);
    run_drain(33, 0, -1);

    run_drain(0, 0, -1);

    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    run_drain(300, 0, -1);

    fill_sorted(33);
    abort_drain();
    run_drain(33, 0, -1);
    run_drain(33, 0, 20);

    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) begin
        ram[0] = DW'($urandom_range(0, 3));
        for (int i = 1; i < DEPTH; i++)
          ram[i] = (ram[i-1] == 8'hFF) ? 8'hFF : ram[i-1] + DW'($urandom_range(0, 1));
      end else begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
      end
      run_drain(int'($urandom_range(0, 300)), 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sort_drain.md
Name: sort_drain

Overview:
- Downstream stage of sort_top.
- After the sorter signals completion, reads its result memory sequentially from address 0 to n-1 and streams each word out on a valid/ready interface.
- Checks on the fly that the stream is non-decreasing and reports a sticky order error plus an emitted-word count.
- Sits between the sorter's result RAM read port and whatever consumer (UART/logger/bench monitor) takes the sorted data.

Parameters:
- DATAWIDTH, 8, width of each data word.
- ADDRWIDTH, 9, width of memory address and of n.
- DEPTH, 256, number of words in the result memory; larger n is clamped to DEPTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- done  input  1  single-cycle pulse from sorter: result memory is valid.
- n  input  ADDRWIDTH  number of words to drain, sampled on the done cycle.
- mem_rd  output  1  read enable to result RAM.
- mem_addr  output  ADDRWIDTH  read address to result RAM.
- mem_rdata  input  DATAWIDTH  RAM read data, valid exactly 1 cycle after mem_rd.
- out_data  output  DATAWIDTH  streamed word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- out_last  output  1  high with the final word (index n-1).
- busy  output  1  high from the cycle after done until drain complete.
- drain_done  output  1  single-cycle pulse when the last word is accepted (or immediately for n=0).
- order_err  output  1  sticky: some word was smaller than its predecessor.
- out_count  output  ADDRWIDTH  number of words accepted in the current or last drain.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including out_count and order_err; internal index and prev-word registers 0.
- FSM states: IDLE, FETCH, CAPTURE, SEND, FINISH.
- IDLE:
  - done=1 latches n_lat = min(n, DEPTH), clears order_err and out_count, sets idx=0.
  - If n_lat=0, go to FINISH; else go to FETCH.
  - done is ignored in every non-IDLE state.
- FETCH: mem_rd=1, mem_addr=idx; next state CAPTURE.
- CAPTURE: register mem_rdata into out_data; out_last = (idx == n_lat-1).
  - If idx>0 and mem_rdata < prev, set order_err (unsigned compare).
  - Next state SEND.
- SEND: out_valid=1, out_data and out_last held stable until handshake.
  - On out_valid & out_ready: prev <= out_data, out_count++.
  - If out_last, go to FINISH; else idx++ and go to FETCH.
  - out_valid never drops without a handshake.
- FINISH: drain_done=1 for one cycle, busy=0; next state IDLE.
- busy=1 in FETCH, CAPTURE and SEND; busy=0 in IDLE and FINISH.
- Latency:
  - done at cycle t gives first out_valid at t+3 (FETCH t+1, CAPTURE t+2, SEND t+3).
  - With out_ready held high, one word is emitted every 3 cycles.
- mem_addr holds its last value outside FETCH; mem_rd=0 outside FETCH.
- out_count saturates naturally at n_lat ≤ DEPTH, so no wrap occurs.
- Reset mid-drain aborts immediately: no drain_done, out_valid drops asynchronously.

Decomposition:
- Shared package (sort_pkg): DATAWIDTH/ADDRWIDTH/DEPTH defaults, FSM state encoding constants.
- One natural sub-module: sort_order_chk, which holds the prev register, the compare and the sticky order_err. The FSM stays in sort_drain.

Test Plan:
- Sorted RAM {1,2,...,33}, n=33, out_ready=1, done pulse:
  - 33 words 1..33 in order, out_last only on 33, first out_valid 3 cycles after done.
  - drain_done pulses once; out_count=33; order_err=0.
- Same data, out_ready toggled 1-of-4 cycles:
  - Identical word sequence; out_data stable while out_valid & !out_ready; no word lost or duplicated.
- RAM {5,7,6,9}, n=4:
  - Words 5,7,6,9 emitted; order_err goes 1 when 6 is captured and stays 1.
  - A following done with sorted data clears it.
- n=0, done:
  - No out_valid, no mem_rd; drain_done pulses the cycle after done; out_count=0.
- n=300, DEPTH=256: exactly 256 words, mem_addr 0..255, out_last on address 255.
- Mid-drain reset and stray done:
  - rst asserted during SEND of word 10: out_valid and busy go 0 immediately, no drain_done, out_count=0.
  - After reset, a new done with n=33 drains fully.
  - A done pulse while busy is ignored.
